// File: rtl/ro_mon_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the ring-oscillator frequency monitor.
package ro_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } mon_state_e;

    localparam int RO_STAGES_DEF   = 31;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_CYC_DEF  = 4;

    // Channel-select width; a single-channel build still carries a 1-bit select.
    function automatic int ch_w(input int num_ch);
        if (num_ch <= 1) begin
            return 1;
        end else begin
            return $clog2(num_ch);
        end
    endfunction

endpackage

// File: rtl/ro_ring.sv
`timescale 1ns/1ps
// One gated ring oscillator: NAND2 enable gate plus RO_STAGES-1 inverters, static low when disabled.
(* keep_hierarchy *)
module ro_ring #(
    parameter int RO_STAGES  = 31,
    parameter int RO_HALF_NS = 0
) (
    input  logic en,
    output logic osc_out
);

`ifdef GL_TEST
    (* keep *) logic [RO_STAGES-1:0] node;

    (* keep *) sg13g2_nand2_1 u_nand (.A(en), .B(node[RO_STAGES-1]), .Y(node[0]));

    for (genvar s = 1; s < RO_STAGES; s++) begin : g_inv
        (* keep *) sg13g2_inv_1 u_inv (.A(node[s-1]), .Y(node[s]));
    end

    // Tap after the first inverter so a disabled ring rests at 0.
    assign osc_out = node[1];
`else
    localparam int HALF_NS = (RO_HALF_NS > 0) ? RO_HALF_NS : RO_STAGES;

    logic osc;

    // Behavioural ring: toggles every HALF_NS while enabled, parks low otherwise.
    always begin
        if (en) begin
            #(HALF_NS);
            osc = ~osc & en;
        end else begin
            osc = 1'b0;
            @(posedge en);
        end
    end

    // Gating with en makes the output drop the instant the ring is disabled.
    assign osc_out = osc & en;
`endif

endmodule

// File: rtl/ro_freq_monitor.sv
`timescale 1ns/1ps
// Multi-channel ring-oscillator process monitor: counts selected-ring edges over a
// programmable clk window and checks the count against inclusive lo/hi bounds.
module ro_freq_monitor
    import ro_mon_pkg::*;
#(
    parameter int              NUM_CH         = 4,
    parameter int              RO_STAGES      = RO_STAGES_DEF,
    parameter int              WIN_W          = 16,
    parameter int              CNT_W          = 24,
    parameter int              SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int              SETTLE_CYC     = SETTLE_CYC_DEF,
    parameter int              RO_HALF_NS     = 0,
    parameter logic [127:0]    RO_HALF_NS_OVR = 128'd0,
    localparam int             CH_W           = ch_w(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] lo_bound,
    input  logic [CNT_W-1:0] hi_bound,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [CH_W-1:0]  result_ch,
    output logic             in_range,
    output logic             overflow
);

    localparam int              SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);

    mon_state_e             state;
    mon_state_e             state_next;
    logic [CH_W-1:0]        ch_clamp;
    logic [CH_W-1:0]        ch_lat;
    logic [CH_W-1:0]        en_ch;
    logic [WIN_W-1:0]       win_lat;
    logic [WIN_W-1:0]       win_cnt;
    logic [CNT_W-1:0]       lo_lat;
    logic [CNT_W-1:0]       hi_lat;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf;
    logic [SET_W-1:0]       settle_cnt;
    logic [NUM_CH-1:0]      ring_en;
    logic [NUM_CH-1:0]      ring_en_next;
    logic [NUM_CH-1:0]      ring_out;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;
    logic                   edge_seen;
    logic                   sel_osc;
    logic                   accept;
    logic                   settle_last;
    logic                   meas_last;

    if (NUM_CH < (1 << CH_W)) begin : g_clamp
        assign ch_clamp = (ch_sel > CH_MAX) ? CH_MAX : ch_sel;
    end else begin : g_no_clamp
        assign ch_clamp = ch_sel;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ring
        localparam int OVR_NS = int'(RO_HALF_NS_OVR[i*16 +: 16]);

        ro_ring #(
            .RO_STAGES  (RO_STAGES),
            .RO_HALF_NS ((OVR_NS != 0) ? OVR_NS : RO_HALF_NS)
        ) u_ring (
            .en      (ring_en[i]),
            .osc_out (ring_out[i])
        );
    end

    // Only one ring runs at a time, so muxing ahead of the synchroniser is safe.
    assign sel_osc   = ring_out[ch_lat];
    assign edge_seen = sync[SYNC_STAGES-1] & ~sync_d;

    // Ring-to-clk synchroniser and rising-edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= {SYNC_STAGES{1'b0}};
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], sel_osc};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    // Next-state logic and ring-enable decode.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        settle_last  = (settle_cnt == {SET_W{1'b0}});
        meas_last    = (win_cnt == WIN_W'(1));
        ring_en_next = {NUM_CH{1'b0}};
        case (state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = ST_SETTLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!settle_last) begin
                    state_next = ST_SETTLE;
                end else if (win_lat == {WIN_W{1'b0}}) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (meas_last) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_MEASURE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (accept) begin
            en_ch = ch_clamp;
        end else begin
            en_ch = ch_lat;
        end
        if ((state_next == ST_SETTLE) || (state_next == ST_MEASURE)) begin
            ring_en_next = NUM_CH'(1'b1) << en_ch;
        end else begin
            ring_en_next = {NUM_CH{1'b0}};
        end
    end

    // State register and registered ring enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ring_en <= {NUM_CH{1'b0}};
        end else begin
            state   <= state_next;
            ring_en <= ring_en_next;
        end
    end

    // Measurement datapath: request latching, settle/window timers, edge counter, result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_lat     <= {CH_W{1'b0}};
            win_lat    <= {WIN_W{1'b0}};
            win_cnt    <= {WIN_W{1'b0}};
            lo_lat     <= {CNT_W{1'b0}};
            hi_lat     <= {CNT_W{1'b0}};
            cnt        <= {CNT_W{1'b0}};
            ovf        <= 1'b0;
            settle_cnt <= {SET_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= {CNT_W{1'b0}};
            result_ch  <= {CH_W{1'b0}};
            in_range   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ch_lat     <= ch_clamp;
                        win_lat    <= win_len;
                        lo_lat     <= lo_bound;
                        hi_lat     <= hi_bound;
                        cnt        <= {CNT_W{1'b0}};
                        ovf        <= 1'b0;
                        settle_cnt <= SET_W'(SETTLE_CYC - 1);
                        busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_last) begin
                        win_cnt <= win_lat;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    win_cnt <= win_cnt - WIN_W'(1);
                    if (edge_seen) begin
                        if (cnt == CNT_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    count     <= cnt;
                    result_ch <= ch_lat;
                    overflow  <= ovf;
                    in_range  <= !ovf && (cnt >= lo_lat) && (cnt <= hi_lat);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for ro_freq_monitor: a 24-bit main instance and a 4-bit-counter instance.
module tb_ro_freq_monitor;

    localparam int SETTLE = 4;

    typedef struct {
        longint cyc;
        longint cnt;
        longint tol;
        bit     inr;
        bit     ovf;
        longint ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic [1:0]  ch_sel, ch_sel4;
    logic [15:0] win_len, win_len4;
    logic [23:0] lo_bound, hi_bound;
    logic [3:0]  lo4, hi4;
    logic        busy, done, in_range, overflow;
    logic [23:0] count;
    logic [1:0]  result_ch;
    logic        busy4, done4, in_range4, overflow4;
    logic [3:0]  count4;
    logic [1:0]  result_ch4;

    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    exp_t   exp_q[$];
    exp_t   exp4_q[$];
    int     ring_rise [4];
    logic [3:0] ring_prev = 4'd0;

    ro_freq_monitor #(
        .NUM_CH(4), .CNT_W(24), .RO_HALF_NS(35),
        .RO_HALF_NS_OVR({64'd0, 16'd50, 16'd30, 16'd20, 16'd0})
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .win_len(win_len),
        .lo_bound(lo_bound), .hi_bound(hi_bound), .busy(busy), .done(done),
        .count(count), .result_ch(result_ch), .in_range(in_range), .overflow(overflow)
    );

    ro_freq_monitor #(
        .NUM_CH(4), .CNT_W(4), .RO_HALF_NS(35)
    ) dut4 (
        .clk(clk), .rst(rst), .start(start4), .ch_sel(ch_sel4), .win_len(win_len4),
        .lo_bound(lo4), .hi_bound(hi4), .busy(busy4), .done(done4),
        .count(count4), .result_ch(result_ch4), .in_range(in_range4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(dut.ring_out) begin
        for (int i = 0; i < 4; i++) begin
            if (dut.ring_out[i] && !ring_prev[i]) ring_rise[i] = ring_rise[i] + 1;
        end
        ring_prev = dut.ring_out;
    end

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
        n_tests++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input longint c, input longint ch,
                              input bit inr, input bit ovf);
        check({tag, "_cycle"}, cyc, e.cyc);
        check({tag, "_count"}, c, e.cnt, e.tol);
        check({tag, "_ch"}, ch, e.ch);
        check({tag, "_in_range"}, inr, e.inr);
        check({tag, "_overflow"}, ovf, e.ovf);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_done("main", e, count, result_ch, in_range, overflow);
            end
        end
        if (done4) begin
            if (exp4_q.size() == 0) begin
                check("spurious_done4", 1, 0);
            end else begin
                e = exp4_q.pop_front();
                check_done("cnt4", e, count4, result_ch4, in_range4, overflow4);
            end
        end
    end

    // Called at a negedge; holds start for exactly one cycle and queues the expected result.
    task automatic send(input bit to4, input int ch, input int win, input int lo, input int hi,
                        input int ecnt, input int etol, input bit einr, input bit eovf);
        exp_t e;
        e.cyc = cyc + 2 + SETTLE + win;
        e.cnt = ecnt;
        e.tol = etol;
        e.inr = einr;
        e.ovf = eovf;
        e.ch  = ch;
        if (to4) begin
            start4 = 1'b1; ch_sel4 = 2'(ch); win_len4 = 16'(win); lo4 = 4'(lo); hi4 = 4'(hi);
            exp4_q.push_back(e);
        end else begin
            start = 1'b1; ch_sel = 2'(ch); win_len = 16'(win); lo_bound = 24'(lo); hi_bound = 24'(hi);
            exp_q.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size() + exp4_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int r0, r1, r2, r3, n;
        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        ch_sel = 2'd0; win_len = 16'd0; lo_bound = 24'd0; hi_bound = 24'd0;
        ch_sel4 = 2'd0; win_len4 = 16'd0; lo4 = 4'd0; hi4 = 4'd0;
        for (int i = 0; i < 4; i++) ring_rise[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_result_ch", result_ch, 0);
        check("rst_in_range", in_range, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(1'b0, 0, 700, 95, 105, 100, 1, 1'b1, 1'b0);
        check("busy_after_start", busy, 1);
        wait_drain(1000);

        send(1'b0, 0, 700, 50, 60, 100, 1, 1'b0, 1'b0);
        wait_drain(1000);
        send(1'b0, 0, 700, 110, 90, 100, 1, 1'b0, 1'b0);
        wait_drain(1000);

        // Zero window, a start while busy, and a start during the done cycle.
        send(1'b0, 1, 0, 0, 5, 0, 0, 1'b1, 1'b0);
        start = 1'b1; ch_sel = 2'd3; win_len = 16'd50;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1; ch_sel = 2'd2; win_len = 16'd10;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_ignored", busy, 0);
        repeat (80) @(negedge clk);
        check("hold_result_ch", result_ch, 1);
        check("hold_count", count, 0);
        wait_drain(10);

        r0 = ring_rise[0]; r1 = ring_rise[1]; r2 = ring_rise[2]; r3 = ring_rise[3];
        send(1'b0, 2, 600, 90, 110, 100, 1, 1'b1, 1'b0);
        wait_drain(1000);
        check("ring0_quiet", ring_rise[0] - r0, 0);
        check("ring1_quiet", ring_rise[1] - r1, 0);
        check("ring3_quiet", ring_rise[3] - r3, 0);
        check("ring2_active", (ring_rise[2] - r2) > 90, 1);

        // Reset in the middle of a measurement.
        send(1'b0, 0, 700, 95, 105, 100, 1, 1'b1, 1'b0);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", count, 0);
        check("midrst_result_ch", result_ch, 0);
        check("midrst_in_range", in_range, 0);
        check("midrst_rings_off", dut.ring_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_still_idle", busy, 0);
        send(1'b0, 0, 700, 95, 105, 100, 1, 1'b1, 1'b0);
        wait_drain(1000);

        send(1'b1, 0, 1000, 0, 15, 15, 0, 1'b0, 1'b1);
        wait_drain(1200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
